// File: rtl/can_rx_drain_ctrl_pkg.sv
// Shared types and frame-decoding helpers for the CAN FD receive drain sequencer.
// Covers the word0 field layout, the DLC-to-byte decoding and the word-count arithmetic.
package can_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        STREAM = 3'd2,
        REL    = 3'd3,
        GAP    = 3'd4
    } state_t;

    // Layout of word0 in the FIFO read window.
    typedef struct packed {
        logic [22:0] rsvd;
        logic        esi;
        logic        brs;
        logic        fdf;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
    } word0_t;

    localparam int W0_DLC_LSB = 0;
    localparam int W0_DLC_MSB = 3;
    localparam int W0_RTR     = 4;
    localparam int W0_FDF     = 6;

    localparam int BYTES_W = 7;
    localparam int WORDS_W = 5;

    // Classic remote frames carry no payload; FD frames have no remote form.
    function automatic logic [BYTES_W-1:0] dlc_to_bytes(
        input logic [3:0] dlc,
        input logic       fdf,
        input logic       rtr
    );
        logic [BYTES_W-1:0] nbytes;
        nbytes = '0;
        if (rtr && !fdf) begin
            nbytes = 7'd0;
        end else if (dlc <= 4'd8) begin
            nbytes = {3'b000, dlc};
        end else if (!fdf) begin
            nbytes = 7'd8;
        end else begin
            case (dlc)
                4'd9:    nbytes = 7'd12;
                4'd10:   nbytes = 7'd16;
                4'd11:   nbytes = 7'd20;
                4'd12:   nbytes = 7'd24;
                4'd13:   nbytes = 7'd32;
                4'd14:   nbytes = 7'd48;
                default: nbytes = 7'd64;
            endcase
        end
        return nbytes;
    endfunction

    // Two header words plus the payload rounded up to whole 32-bit words.
    function automatic logic [WORDS_W-1:0] bytes_to_words(
        input logic [BYTES_W-1:0] nbytes
    );
        logic [BYTES_W-1:0] words;
        words = 7'd2 + ((nbytes + 7'd3) >> 2);
        return words[WORDS_W-1:0];
    endfunction

endpackage

// File: rtl/can_rx_drain_ctrl_stream_reg.sv
// Output register stage of the drain stream: holds one word with valid/last flags.
// A flush drops the held word without a handshake.
module can_rx_stream_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        m_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic        m_last
);

    logic        valid_reg;
    logic [31:0] data_reg;
    logic        last_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            last_reg  <= load_last;
        end else if (valid_reg && m_ready) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end
    end

    assign m_valid = valid_reg;
    assign m_data  = data_reg;
    assign m_last  = last_reg;

endmodule

// File: rtl/can_rx_drain_ctrl.sv
// Read-side sequencer for the CAN FD RX FIFO: walks the head frame through the read
// window, streams its words over valid/ready, then releases the frame.
module can_rx_drain_ctrl
    import can_rx_pkg::*;
#(
    parameter logic [5:0] WIN_BASE = 6'd16,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             reset_mode,
    input  logic             info_empty,
    input  logic             overrun,
    input  logic [31:0]      fifo_data,
    output logic [5:0]       fifo_addr,
    output logic             fifo_selected,
    output logic             release_buffer,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic             m_ovr,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] ovr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t               state_reg;
    logic [WORDS_W-1:0]   idx_reg;
    logic [WORDS_W-1:0]   total_reg;
    logic                 done_reg;
    logic [5:0]           addr_reg;
    logic                 sel_reg;
    logic                 busy_reg;
    logic                 rel_reg;
    logic                 ovr_reg;
    logic [CNT_W-1:0]     frame_cnt_reg;
    logic [CNT_W-1:0]     ovr_cnt_reg;

    logic                 load_next;
    logic                 last_word_next;
    logic                 accept_last_next;

    // Refill the output register whenever it is empty or being drained this cycle.
    always_comb begin
        load_next        = 1'b0;
        last_word_next   = 1'b0;
        accept_last_next = 1'b0;
        if (state_reg == STREAM) begin
            load_next        = !done_reg && (!m_valid || m_ready) && !reset_mode;
            last_word_next   = (idx_reg == (total_reg - 5'd1));
            accept_last_next = m_valid && m_ready && m_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            total_reg     <= '0;
            done_reg      <= 1'b0;
            addr_reg      <= WIN_BASE;
            sel_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            rel_reg       <= 1'b0;
            ovr_reg       <= 1'b0;
            frame_cnt_reg <= '0;
            ovr_cnt_reg   <= '0;
        end else begin
            rel_reg <= 1'b0;
            if (reset_mode) begin
                state_reg <= IDLE;
                idx_reg   <= '0;
                done_reg  <= 1'b0;
                addr_reg  <= WIN_BASE;
                sel_reg   <= 1'b0;
                busy_reg  <= 1'b0;
                ovr_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        addr_reg <= WIN_BASE;
                        if (enable && !info_empty) begin
                            state_reg <= HDR;
                            sel_reg   <= 1'b1;
                            busy_reg  <= 1'b1;
                        end
                    end
                    HDR: begin
                        total_reg <= bytes_to_words(dlc_to_bytes(
                                         fifo_data[W0_DLC_MSB:W0_DLC_LSB],
                                         fifo_data[W0_FDF],
                                         fifo_data[W0_RTR]));
                        ovr_reg   <= overrun;
                        idx_reg   <= '0;
                        done_reg  <= 1'b0;
                        state_reg <= STREAM;
                    end
                    STREAM: begin
                        // The address stops on the last word so it never leaves the window.
                        if (load_next) begin
                            idx_reg <= idx_reg + 5'd1;
                            if (last_word_next) begin
                                done_reg <= 1'b1;
                            end else begin
                                addr_reg <= addr_reg + 6'd1;
                            end
                        end
                        if (accept_last_next) begin
                            state_reg <= REL;
                            sel_reg   <= 1'b0;
                            rel_reg   <= 1'b1;
                        end
                    end
                    REL: begin
                        frame_cnt_reg <= frame_cnt_reg + CNT_ONE;
                        if (ovr_reg) begin
                            ovr_cnt_reg <= ovr_cnt_reg + CNT_ONE;
                        end
                        state_reg <= GAP;
                    end
                    GAP: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        addr_reg  <= WIN_BASE;
                    end
                    default: begin
                        state_reg <= IDLE;
                        sel_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        addr_reg  <= WIN_BASE;
                    end
                endcase
            end
        end
    end

    can_rx_stream_reg u_stream_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (reset_mode),
        .load      (load_next),
        .load_data (fifo_data),
        .load_last (last_word_next),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    assign fifo_addr      = addr_reg;
    assign fifo_selected  = sel_reg;
    assign release_buffer = rel_reg;
    assign m_ovr          = ovr_reg;
    assign busy           = busy_reg;
    assign frame_cnt      = frame_cnt_reg;
    assign ovr_cnt        = ovr_cnt_reg;

endmodule

// File: tb/tb_can_rx_drain_ctrl.sv
// Directed bench for can_rx_drain_ctrl: a table of frames with hand-computed word counts,
// plus sequences for abort and enable drop.
module tb_can_rx_drain_ctrl;

    localparam int CNT_W = 16;
    localparam int BASE  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             reset_mode;
    logic             info_empty;
    logic             overrun;
    logic [31:0]      fifo_data;
    logic [5:0]       fifo_addr;
    logic             fifo_selected;
    logic             release_buffer;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             m_last;
    logic             m_ovr;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] ovr_cnt;

    logic [31:0] fifo_mem [0:63];
    assign fifo_data = fifo_mem[fifo_addr];

    always #5 clk = ~clk;

    can_rx_drain_ctrl #(.WIN_BASE(6'd16), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .reset_mode     (reset_mode),
        .info_empty     (info_empty),
        .overrun        (overrun),
        .fifo_data      (fifo_data),
        .fifo_addr      (fifo_addr),
        .fifo_selected  (fifo_selected),
        .release_buffer (release_buffer),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_ovr          (m_ovr),
        .busy           (busy),
        .frame_cnt      (frame_cnt),
        .ovr_cnt        (ovr_cnt)
    );

    typedef struct {
        logic [3:0] dlc;
        bit         rtr;
        bit         fdf;
        bit         ovr;
        int         mode;       // 0: m_ready held high, 1: m_ready toggles
        int         exp_words;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_frames = 0;
    int          exp_ovrs = 0;
    logic [31:0] got_data [$];
    bit          got_last [$];
    bit          got_ovr  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_frame(input logic [3:0] dlc, input bit rtr, input bit fdf, input logic [7:0] tag);
        logic [31:0] w0;
        w0       = 32'h0;
        w0[3:0]  = dlc;
        w0[4]    = rtr;
        w0[6]    = fdf;
        w0[7]    = fdf;
        w0[31:24] = tag;
        for (int a = 0; a < 64; a++) fifo_mem[a] = {16'hDEAD, 8'h00, a[7:0]};
        fifo_mem[BASE]     = w0;
        fifo_mem[BASE + 1] = {3'b000, 21'h1ABC0, tag};
        for (int k = 2; k < 18; k++) fifo_mem[BASE + k] = {tag, 8'hD0, 8'h00, k[7:0]};
    endtask

    // Drains one frame from a negedge; returns timing observations and fills the got_* queues.
    task automatic run_frame(input int mode, input bit drop_en, output int busy_cyc,
                             output int rel_cyc, output int rel_delay, output int max_addr);
        bit seen_busy;
        bit finished;
        bit prev_stall;
        logic [31:0] prev_data;
        int last_hs;
        got_data.delete();
        got_last.delete();
        got_ovr.delete();
        busy_cyc = 0; rel_cyc = 0; rel_delay = -1; max_addr = 0; last_hs = -1;
        seen_busy = 0; finished = 0; prev_stall = 0; prev_data = '0;
        enable = 1'b1;
        info_empty = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (busy) begin
                seen_busy = 1;
                busy_cyc++;
                info_empty = 1'b1;
                if (drop_en) enable = 1'b0;
            end
            if (fifo_selected && int'(fifo_addr) > max_addr) max_addr = int'(fifo_addr);
            if (prev_stall) begin
                check("stall_data_hold", m_data, prev_data);
                check("stall_valid_hold", 32'(m_valid), 32'd1);
            end
            if (release_buffer) begin
                rel_cyc++;
                if (last_hs >= 0) rel_delay = cyc - last_hs;
            end
            m_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_ovr.push_back(m_ovr);
                if (m_last) last_hs = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (seen_busy && !busy) begin
                finished = 1;
                break;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout actual=busy_stuck required=idle_within_300");
        end
    endtask

    task automatic check_words(input int exp_words, input bit exp_ovr);
        check("word_count", 32'(got_data.size()), 32'(exp_words));
        for (int k = 0; k < got_data.size() && k < exp_words; k++) begin
            check($sformatf("word%0d_data", k), got_data[k], fifo_mem[BASE + k]);
            check($sformatf("word%0d_last", k), 32'(got_last[k]), 32'(k == exp_words - 1));
            check($sformatf("word%0d_ovr", k), 32'(got_ovr[k]), 32'(exp_ovr));
        end
    endtask

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cyc, rel_cyc, rel_delay, max_addr, hs, idle_busy;
        bit aborted;

        vecs[0]  = '{4'd8,  1'b0, 1'b0, 1'b0, 0, 4};
        vecs[1]  = '{4'd15, 1'b0, 1'b1, 1'b0, 0, 18};
        vecs[2]  = '{4'd4,  1'b1, 1'b0, 1'b0, 0, 2};
        vecs[3]  = '{4'd6,  1'b0, 1'b0, 1'b0, 1, 4};
        vecs[4]  = '{4'd2,  1'b0, 1'b0, 1'b1, 0, 3};
        vecs[5]  = '{4'd1,  1'b0, 1'b0, 1'b0, 0, 3};
        vecs[6]  = '{4'd9,  1'b0, 1'b0, 1'b0, 0, 4};
        vecs[7]  = '{4'd9,  1'b0, 1'b1, 1'b0, 0, 5};
        vecs[8]  = '{4'd12, 1'b0, 1'b1, 1'b0, 0, 8};
        vecs[9]  = '{4'd3,  1'b1, 1'b1, 1'b0, 0, 3};
        vecs[10] = '{4'd0,  1'b0, 1'b0, 1'b0, 0, 2};
        vecs[11] = '{4'd13, 1'b0, 1'b1, 1'b1, 1, 10};

        rst = 1'b1;
        enable = 1'b0;
        reset_mode = 1'b0;
        info_empty = 1'b0;
        overrun = 1'b0;
        m_ready = 1'b0;
        load_frame(4'd8, 1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_last", 32'(m_last), 32'd0);
        check("reset_m_ovr", 32'(m_ovr), 32'd0);
        check("reset_release", 32'(release_buffer), 32'd0);
        check("reset_fifo_sel", 32'(fifo_selected), 32'd0);
        check("reset_fifo_addr", 32'(fifo_addr), 32'd16);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset_ovr_cnt", 32'(ovr_cnt), 32'd0);
        idle_busy = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        check("disabled_stays_idle", 32'(idle_busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            load_frame(vecs[i].dlc, vecs[i].rtr, vecs[i].fdf, 8'(i + 1));
            overrun = vecs[i].ovr;
            run_frame(vecs[i].mode, 1'b0, busy_cyc, rel_cyc, rel_delay, max_addr);
            exp_frames++;
            if (vecs[i].ovr) exp_ovrs++;
            check_words(vecs[i].exp_words, vecs[i].ovr);
            check("release_cycles", 32'(rel_cyc), 32'd1);
            check("release_delay", 32'(rel_delay), 32'd1);
            check("max_fifo_addr", 32'(max_addr), 32'(BASE + vecs[i].exp_words - 1));
            check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
            check("ovr_cnt", 32'(ovr_cnt), 32'(exp_ovrs));
            if (vecs[i].mode == 0) check("busy_cycles", 32'(busy_cyc), 32'(vecs[i].exp_words + 4));
            $display("frame %0d dlc=%0d rtr=%0d fdf=%0d ovr=%0d words=%0d busy=%0d",
                     i, vecs[i].dlc, vecs[i].rtr, vecs[i].fdf, vecs[i].ovr, got_data.size(), busy_cyc);
        end

        // Abort on word 3 of an 18-word frame.
        load_frame(4'd15, 1'b0, 1'b1, 8'hA0);
        overrun = 1'b1;
        enable = 1'b1;
        info_empty = 1'b0;
        m_ready = 1'b1;
        hs = 0;
        aborted = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_valid && hs == 2) begin
                reset_mode = 1'b1;
                aborted = 1;
                break;
            end
            if (m_valid && m_ready) hs++;
        end
        check("abort_reached_word3", 32'(aborted), 32'd1);
        @(negedge clk);
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_m_last", 32'(m_last), 32'd0);
        check("abort_m_ovr", 32'(m_ovr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fifo_sel", 32'(fifo_selected), 32'd0);
        check("abort_fifo_addr", 32'(fifo_addr), 32'd16);
        rel_cyc = int'(release_buffer);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (release_buffer || busy) rel_cyc++;
        end
        check("abort_no_release", 32'(rel_cyc), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("abort_ovr_cnt", 32'(ovr_cnt), 32'(exp_ovrs));
        $display("abort after %0d words, frame_cnt=%0d", hs, frame_cnt);
        reset_mode = 1'b0;

        run_frame(0, 1'b0, busy_cyc, rel_cyc, rel_delay, max_addr);
        exp_frames++;
        exp_ovrs++;
        check_words(18, 1'b1);
        check("post_abort_release", 32'(rel_cyc), 32'd1);
        check("post_abort_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("post_abort_ovr_cnt", 32'(ovr_cnt), 32'(exp_ovrs));
        $display("post-abort frame words=%0d busy=%0d", got_data.size(), busy_cyc);

        // enable dropped mid-frame: frame completes, then no new frame starts.
        load_frame(4'd3, 1'b0, 1'b0, 8'hB0);
        overrun = 1'b0;
        run_frame(0, 1'b1, busy_cyc, rel_cyc, rel_delay, max_addr);
        exp_frames++;
        check_words(3, 1'b0);
        check("en_drop_release", 32'(rel_cyc), 32'd1);
        check("en_drop_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        info_empty = 1'b0;
        idle_busy = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        check("en_drop_stays_idle", 32'(idle_busy), 32'd0);
        $display("enable-drop frame words=%0d idle_busy=%0d", got_data.size(), idle_busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
